// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive bit sampler.
// The PARITY state is only reachable when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_HALF_BIT   = 8;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_baud_tick.sv
// Oversample tick generator: one tick every BAUD_DIV clocks, with a sync clear
// so the tick phase can be realigned to a detected falling edge.
module uart_rx_baud_tick #(
    parameter int BAUD_DIV = 27
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tick_o = (count_q == LAST);

endmodule

// File: rtl/uart_receiver_bit_sampler.sv
// UART receive bit sampler: synchroniser, start detect, 16x oversampling, LSB-first shift.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
import uart_pkg::*;

module uart_receiver_bit_sampler #(
    parameter int BAUD_DIV = 27
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] shift_reg_data,
    output logic       load_data_out,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       busy_o
);

    localparam logic [3:0] HALF_LAST = 4'(UART_HALF_BIT - 1);
    localparam logic [3:0] BIT_LAST  = 4'(UART_OVERSAMPLE - 1);
    localparam logic [2:0] DATA_LAST = 3'(UART_DATA_BITS - 1);

    uart_rx_state_t state_q;
    logic [1:0]     rxSync_q;
    logic           rx_s;
    logic           armed_q;
    logic [3:0]     tickCnt_q;
    logic [2:0]     bitCnt_q;
    logic [7:0]     shiftReg_q;
    logic [7:0]     shift_d;
    logic           load_q;
    logic           frameErr_q;
    logic           tick;
    logic           startDetect;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxSync_q <= 2'b00;
        end else begin
            rxSync_q <= {rxSync_q[0], rx_i};
        end
    end

    assign rx_s        = rxSync_q[1];
    assign startDetect = (state_q == ST_IDLE) && armed_q && !rx_s;
    assign shift_d     = {rx_s, shiftReg_q[7:1]};

    uart_rx_baud_tick #(
        .BAUD_DIV(BAUD_DIV)
    ) u_tick (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (startDetect),
        .tick_o(tick)
    );

`ifdef UART_RX_PARITY_EN
    logic parity_q;
    logic parityErr_q;
    logic parityBad;

    assign parityBad    = (^shiftReg_q) ^ parity_q;
    assign parity_err_o = parityErr_q;
`else
    assign parity_err_o = 1'b0;
`endif

    // Bit-timing FSM; tickCnt_q counts oversample ticks within the current bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b0;
            tickCnt_q  <= '0;
            bitCnt_q   <= '0;
            shiftReg_q <= '0;
            load_q     <= 1'b0;
            frameErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q    <= 1'b0;
            parityErr_q <= 1'b0;
`endif
        end else begin
            load_q     <= 1'b0;
            frameErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityErr_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (rx_s) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        armed_q   <= 1'b0;
                        tickCnt_q <= '0;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (tickCnt_q == HALF_LAST) begin
                            tickCnt_q <= '0;
                            bitCnt_q  <= '0;
                            state_q   <= rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            tickCnt_q <= tickCnt_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (tickCnt_q == BIT_LAST) begin
                            tickCnt_q  <= '0;
                            shiftReg_q <= shift_d;
                            bitCnt_q   <= bitCnt_q + 1'b1;
                            if (bitCnt_q == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= ST_PARITY;
`else
                                state_q <= ST_STOP;
`endif
                            end
                        end else begin
                            tickCnt_q <= tickCnt_q + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        if (tickCnt_q == BIT_LAST) begin
                            tickCnt_q <= '0;
                            parity_q  <= rx_s;
                            state_q   <= ST_STOP;
                        end else begin
                            tickCnt_q <= tickCnt_q + 1'b1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        if (tickCnt_q == BIT_LAST) begin
                            tickCnt_q  <= '0;
                            frameErr_q <= !rx_s;
`ifdef UART_RX_PARITY_EN
                            load_q      <= rx_s && !parityBad;
                            parityErr_q <= parityBad;
`else
                            load_q      <= rx_s;
`endif
                            state_q    <= ST_IDLE;
                        end else begin
                            tickCnt_q <= tickCnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign shift_reg_data = shiftReg_q;
    assign load_data_out  = load_q;
    assign frame_err_o    = frameErr_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule
